// File: rtl/spiflash_target.sv
// spiflash_target: mode-0 SPI flash responder (READ/RDID/RDSR); define SPIFLASH_TARGET_FASTREAD_EN to add FAST_READ 0x0B
module spiflash_target #(
  parameter int          AW       = 24,
  parameter logic [23:0] JEDEC_ID = 24'h012018
) (
  input  logic          flash_clock_i,
  input  logic          flash_reset_i,
  input  logic          flash_cs_n,
  input  logic          flash_sck,
  input  logic          flash_mosi,
  output logic          flash_miso,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_data,
  output logic          busy
);
  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DATA, IGNORE
`ifdef SPIFLASH_TARGET_FASTREAD_EN
    , DUMMY
`endif
  } state_t;
  localparam logic [1:0] M_MEM = 2'd0, M_ID = 2'd1, M_SR = 2'd2, M_FAST = 2'd3;
  state_t      state, state_nx;
  logic [1:0]  cs_q, sck_q, mosi_q, mode, mode_nx, id_idx;
  logic        sck_d, rise, fall, live, last, pend, issue_rd, op_mem, op_fast, mem_mode;
  logic [4:0]  cnt;
  logic [22:0] sr;
  logic [23:0] rx;
  logic [7:0]  tx, opcode;
  assign rise     = sck_q[1] & ~sck_d;
  assign fall     = ~sck_q[1] & sck_d;
  assign live     = state != IDLE && state != IGNORE;
  assign last     = rise && live && cnt == (state == ADDR ? 5'd23 : 5'd7);
  assign rx       = {sr, mosi_q[1]};
  assign opcode   = rx[7:0];
  assign mem_mode = mode == M_MEM || mode == M_FAST;
`ifdef SPIFLASH_TARGET_FASTREAD_EN
  assign op_fast  = opcode == 8'h0B;
`else
  assign op_fast  = 1'b0;
`endif
  assign op_mem   = opcode == 8'h03 || op_fast;
  assign mode_nx  = op_fast ? M_FAST : opcode == 8'h9F ? M_ID : opcode == 8'h05 ? M_SR : M_MEM;
  // two-flop synchronizers plus a delayed sck for edge detection
  always_ff @(posedge flash_clock_i or posedge flash_reset_i)
    if (flash_reset_i) begin
      cs_q   <= 2'b11;
      sck_q  <= 2'b00;
      mosi_q <= 2'b00;
      sck_d  <= 1'b0;
    end else begin
      cs_q   <= {cs_q[0], flash_cs_n};
      sck_q  <= {sck_q[0], flash_sck};
      mosi_q <= {mosi_q[0], flash_mosi};
      sck_d  <= sck_q[1];
    end
  // state register
  always_ff @(posedge flash_clock_i or posedge flash_reset_i)
    if (flash_reset_i) state <= IDLE;
    else state <= state_nx;
  // next state: deselect always wins, otherwise advance on the last bit of each phase
  always_comb begin
    state_nx = state;
    if (cs_q[1]) state_nx = IDLE;
    else
      case (state)
        IDLE:  state_nx = CMD;
        CMD:   if (last) state_nx = op_mem ? ADDR : (opcode == 8'h9F || opcode == 8'h05) ? DATA : IGNORE;
`ifdef SPIFLASH_TARGET_FASTREAD_EN
        ADDR:  if (last) state_nx = mode == M_FAST ? DUMMY : DATA;
        DUMMY: if (last) state_nx = DATA;
`else
        ADDR:  if (last) state_nx = DATA;
`endif
        default: ;
      endcase
  end
  // outputs: memory fetch request at the end of the address and of each memory data byte
  always_comb begin
    issue_rd = last && (state == ADDR || (state == DATA && mem_mode));
    busy     = ~cs_q[1];
  end
  // datapath: shift registers, memory port, transmit byte loading and miso drive
  always_ff @(posedge flash_clock_i or posedge flash_reset_i)
    if (flash_reset_i) begin
      cnt        <= 5'd0;
      sr         <= 23'd0;
      tx         <= 8'd0;
      flash_miso <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      pend       <= 1'b0;
      mode       <= M_MEM;
      id_idx     <= 2'd0;
    end else if (cs_q[1]) begin
      cnt        <= 5'd0;
      sr         <= 23'd0;
      tx         <= 8'd0;
      flash_miso <= 1'b0;
      mem_rd     <= 1'b0;
      pend       <= 1'b0;
      id_idx     <= 2'd0;
    end else begin
      mem_rd <= issue_rd;
      pend   <= mem_rd;
      if (rise && live) begin
        sr  <= rx[22:0];
        cnt <= last ? 5'd0 : cnt + 5'd1;
      end
      if (issue_rd && state == ADDR) mem_addr <= rx[AW-1:0];
      if (last && state == CMD) begin
        mode   <= mode_nx;
        id_idx <= 2'd1;
        tx     <= opcode == 8'h9F ? JEDEC_ID[23:16] : 8'h00;
      end
      if (last && state == DATA && mode == M_ID) begin
        tx     <= id_idx == 2'd1 ? JEDEC_ID[15:8] : id_idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
        id_idx <= id_idx == 2'd3 ? 2'd3 : id_idx + 2'd1;
      end
      if (pend) begin
        tx       <= mem_data;
        mem_addr <= mem_addr + AW'(1);
      end
      if (fall) begin
        flash_miso <= state == DATA ? tx[7] : 1'b0;
        if (state == DATA) tx <= {tx[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_spiflash_target.sv
// tb_spiflash_target: scoreboard bench for spiflash_target (AW=24 and AW=8 instances)
module tb_spiflash_target;
  localparam int H = 6;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  logic cs_n = 1, cs8_n = 1, sck = 0, mosi = 0;
  logic miso, miso8, rd, rd8, busy, busy8;
  logic [23:0] addr;
  logic [7:0] addr8, data, data8;
  spiflash_target dut (
    .flash_clock_i(clk), .flash_reset_i(rst), .flash_cs_n(cs_n), .flash_sck(sck),
    .flash_mosi(mosi), .flash_miso(miso), .mem_rd(rd), .mem_addr(addr),
    .mem_data(data), .busy(busy));
  spiflash_target #(.AW(8)) dut8 (
    .flash_clock_i(clk), .flash_reset_i(rst), .flash_cs_n(cs8_n), .flash_sck(sck),
    .flash_mosi(mosi), .flash_miso(miso8), .mem_rd(rd8), .mem_addr(addr8),
    .mem_data(data8), .busy(busy8));
  // memory holds n[7:0] at address n; data is only meaningful the cycle after a strobe
  always @(posedge clk) begin
    data  <= rd ? addr[7:0] : 8'hEE;
    data8 <= rd8 ? addr8 : 8'hEE;
  end
  int vectors = 0, errors = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] rd_q[$];
  logic [7:0]  rd8_q[$];
  logic cap = 0, sel8 = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  // miso monitor: assemble bytes at each sck rise and compare with the queue
  logic [7:0] sh = 0;
  int nb = 0;
  always @(posedge sck)
    if (cap) begin
      sh = {sh[6:0], sel8 ? miso8 : miso};
      nb++;
      if (nb == 8) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL miso_extra: got %h with no byte expected", sh);
        end else check("miso_byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
      end
    end
  // memory strobe monitors: address order and single-cycle pulses
  logic rd_p = 0, rd8_p = 0;
  always @(negedge clk) begin
    if (rd === 1'b1) begin
      if (rd_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL mem_rd_extra: addr %h with none expected", addr);
      end else check("mem_addr", {8'd0, addr}, {8'd0, rd_q.pop_front()});
      if (rd_p) begin
        vectors++; errors++;
        $display("FAIL mem_rd_width: got 2-cycle strobe, required 1");
      end
    end
    if (rd8 === 1'b1) begin
      if (rd8_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL mem_rd8_extra: addr %h with none expected", addr8);
      end else check("mem_addr8", {24'd0, addr8}, {24'd0, rd8_q.pop_front()});
      if (rd8_p) begin
        vectors++; errors++;
        $display("FAIL mem_rd8_width: got 2-cycle strobe, required 1");
      end
    end
    rd_p  = rd === 1'b1;
    rd8_p = rd8 === 1'b1;
  end
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_byte(input logic [7:0] b, input int nbits = 8);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      wait_clks(H);
      sck = 1;
      wait_clks(H);
      sck = 0;
    end
  endtask
  task automatic start(input logic use8);
    sel8 = use8;
    cap  = 1;
    if (use8) cs8_n = 0;
    else cs_n = 0;
    wait_clks(H);
    check("busy_on", {31'd0, use8 ? busy8 : busy}, 32'd1);
  endtask
  task automatic stop;
    wait_clks(H);
    cs_n  = 1;
    cs8_n = 1;
    cap   = 0;
    wait_clks(12);
    check("busy_off", {31'd0, sel8 ? busy8 : busy}, 32'd0);
  endtask
  task automatic hdr(input logic [7:0] op, input logic [23:0] a);
    spi_byte(op);
    spi_byte(a[23:16]);
    spi_byte(a[15:8]);
    spi_byte(a[7:0]);
  endtask
  task automatic zeros(input int n);
    repeat (n) exp_q.push_back(8'h00);
  endtask
  initial begin
    #2 rst = 1;
    wait_clks(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_mem_rd", {31'd0, rd}, 32'd0);
    check("rst_mem_addr", {8'd0, addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 0;
    wait_clks(4);
    // READ 0x000010, 4 bytes
    zeros(4);
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h12); exp_q.push_back(8'h13);
    for (int i = 'h10; i <= 'h14; i++) rd_q.push_back(24'(i));
    start(0); hdr(8'h03, 24'h000010); repeat (4) spi_byte(8'h00); stop;
    // RDID, 4 bytes
    zeros(1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h20); exp_q.push_back(8'h18); exp_q.push_back(8'h00);
    start(0); spi_byte(8'h9F); repeat (4) spi_byte(8'h00); stop;
    // AW=8 READ at 0xAB00FE wraps and ignores upper bits
    zeros(4);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    rd8_q.push_back(8'hFE); rd8_q.push_back(8'hFF); rd8_q.push_back(8'h00); rd8_q.push_back(8'h01);
    start(1); hdr(8'h03, 24'hAB00FE); repeat (3) spi_byte(8'h00); stop;
    // unknown opcode, 16 sck: miso stays 0, no fetch
    zeros(2);
    start(0); spi_byte(8'h42); spi_byte(8'h00); stop;
    // READ after the ignored command works normally
    zeros(4);
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    rd_q.push_back(24'h40); rd_q.push_back(24'h41); rd_q.push_back(24'h42);
    start(0); hdr(8'h03, 24'h000040); repeat (2) spi_byte(8'h00); stop;
    // READ aborted after 4 data bits, then READ 0x000020
    zeros(4);
    rd_q.push_back(24'h30);
    start(0); hdr(8'h03, 24'h000030); cap = 0; spi_byte(8'h00, 4); stop;
    zeros(4);
    exp_q.push_back(8'h20); exp_q.push_back(8'h21);
    rd_q.push_back(24'h20); rd_q.push_back(24'h21); rd_q.push_back(24'h22);
    start(0); hdr(8'h03, 24'h000020); repeat (2) spi_byte(8'h00); stop;
    // FAST_READ 0x000005 with 8 dummy clocks, 2 bytes
`ifdef SPIFLASH_TARGET_FASTREAD_EN
    zeros(5);
    exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    rd_q.push_back(24'h05); rd_q.push_back(24'h06); rd_q.push_back(24'h07);
`else
    zeros(7);
`endif
    start(0); hdr(8'h0B, 24'h000005); spi_byte(8'h00); repeat (2) spi_byte(8'h00); stop;
    wait_clks(20);
    check("miso_bytes_left", exp_q.size(), 32'd0);
    check("mem_rd_left", rd_q.size(), 32'd0);
    check("mem_rd8_left", rd8_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
